mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 16, address width.
REQ-002 SHALL have parameter DATA_W, 16, data width.
REQ-003 SHALL have parameter MAX_WAIT, 15, maximum wait cycles for mem_done before timeout (1..255).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports if_req in 1 (fetch request, level) and if_addr in ADDR_W (fetch address).
REQ-007 SHALL have ports mem_read in 1, mem_write in 1, dm_addr in ADDR_W, dm_wdata in DATA_W: data-side request and payload.
REQ-008 SHALL have port halt  in  1  stop granting fetches.
REQ-009 SHALL have ports if_data out DATA_W, if_valid out 1, if_stall out 1: fetch response.
REQ-010 SHALL have ports dm_rdata out DATA_W, dm_valid out 1, dm_stall out 1: data response.
REQ-011 SHALL have ports mem_en out 1, mem_wr out 1, mem_addr out ADDR_W, mem_wdata out DATA_W: unified memory command.
REQ-012 SHALL have ports mem_rdata in DATA_W and mem_done in 1: memory response.
REQ-013 SHALL have ports halted out 1 (quiesced) and err out 1 (sticky error).

Function
REQ-014 SHALL implement FSM states IDLE, DATA, FETCH, DONE.
REQ-015 In IDLE, mem_read|mem_write SHALL grant data (-> DATA); else if_req & ~halt SHALL grant fetch (-> FETCH); else stay IDLE. Data always wins a simultaneous request.
REQ-016 On grant, mem_addr/mem_wdata/mem_wr SHALL be registered from the winner (fetch: if_addr, mem_wr=0); mem_en SHALL be high for exactly the first cycle in DATA/FETCH.
REQ-017 mem_wr, mem_addr, mem_wdata SHALL hold stable until the state leaves DATA/FETCH.
REQ-018 mem_done SHALL be sampled only from the cycle after mem_en onward; mem_done in the mem_en cycle SHALL be ignored.
REQ-019 On sampled mem_done, mem_rdata SHALL be captured into dm_rdata (DATA) or if_data (FETCH), and the FSM SHALL go to DONE.
REQ-020 DONE SHALL last one cycle, pulse dm_valid or if_valid (matching the served side) for that cycle, grant nothing, and go to IDLE.
REQ-021 Requesters SHALL drop or change their request by the edge ending the DONE cycle; a request still high in the following IDLE is a new request.
REQ-022 if_stall SHALL equal if_req & ~if_valid; dm_stall SHALL equal (mem_read|mem_write) & ~dm_valid; both combinational.
REQ-023 A wait counter SHALL count sampled cycles without mem_done; on reaching MAX_WAIT the transaction SHALL abort to DONE, the captured data SHALL be 0, and err SHALL set.
REQ-024 mem_read & mem_write together at grant SHALL be served as a write and SHALL set err.
REQ-025 err SHALL be sticky and cleared only by reset.
REQ-026 halt SHALL block fetch grants only; a fetch already in progress completes. Data requests are still granted.
REQ-027 halted SHALL equal halt & (state==IDLE) & ~mem_read & ~mem_write.
REQ-028 if_data and dm_rdata SHALL hold their last captured value until the next capture for that side.

Reset
REQ-029 When rst_n=0 at a rising edge: state SHALL become IDLE, wait counter 0, err 0, and mem_en, mem_wr, mem_addr, mem_wdata, if_data, dm_rdata, if_valid, dm_valid all 0.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no valid pulse and no reissue of mem_en; the first grant may occur in the first cycle after rst_n returns to 1.

Verification
REQ-031 Fetch only: if_req=1, if_addr=0x0010, mem_done 2 cycles after mem_en with rdata=0xABCD -> one mem_en pulse (mem_wr=0, addr 0x0010), if_valid for one cycle with if_data=0xABCD, if_stall=1 until then.
REQ-032 Simultaneous: if_req=1 and mem_write=1 (dm_addr=0x0100, wdata=0x1234) in the same IDLE cycle -> write issued first; fetch granted in the IDLE cycle after the data DONE.
REQ-033 Timeout: mem_read=1, mem_done never asserted, MAX_WAIT=15 -> dm_valid 15 sampled cycles after mem_en, dm_rdata=0, err=1 and stays 1.
REQ-034 Halt: halt=1, if_req=1, no data request -> no mem_en, halted=1; then mem_read=1 -> read served, halted=0 during it and 1 after.
REQ-035 Reset mid-read: rst_n=0 one cycle after mem_en -> all outputs 0, no dm_valid, no second mem_en; late mem_done ignored.
REQ-036 Protocol error: mem_read=mem_write=1 -> served with mem_wr=1, err=1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, response and memory-command signals for mem_arbiter.
// "slave" is the arbiter's view; "master" is the surrounding environment's view.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              halt;
   logic [DATA_W-1:0] if_data;
   logic              if_valid;
   logic              if_stall;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              dm_stall;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_done;
   logic              halted;
   logic              err;

   modport slave (
      input  if_req, if_addr, mem_read, mem_write, dm_addr, dm_wdata, halt, mem_rdata, mem_done,
      output if_data, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
      output mem_en, mem_wr, mem_addr, mem_wdata, halted, err
   );

   modport master (
      output if_req, if_addr, mem_read, mem_write, dm_addr, dm_wdata, halt, mem_rdata, mem_done,
      input  if_data, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
      input  mem_en, mem_wr, mem_addr, mem_wdata, halted, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// Data wins ties; one transaction in flight, bounded wait for mem_done.
module mem_arbiter #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MAX_WAIT = 15
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StData, StFetch, StDone} state_e;

   localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

   state_e            state_q, state_d;
   logic [7:0]        wait_q, wait_d;
   logic              mem_en_q, mem_wr_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q, if_data_q, dm_rdata_q;
   logic              if_valid_q, dm_valid_q, err_q;
   logic              data_req, grant_data, grant_fetch, resp_ok, resp_timeout;

   assign data_req = bus.mem_read | bus.mem_write;

   always_comb begin
      state_d      = state_q;
      wait_d       = '0;
      grant_data   = 1'b0;
      grant_fetch  = 1'b0;
      resp_ok      = 1'b0;
      resp_timeout = 1'b0;
      case (state_q)
         StIdle: begin
            if (data_req) begin
               grant_data = 1'b1;
               state_d    = StData;
            end else if (bus.if_req && !bus.halt) begin
               grant_fetch = 1'b1;
               state_d     = StFetch;
            end
         end
         StData, StFetch: begin
            wait_d = wait_q;
            // A mem_done coincident with mem_en cannot belong to this command.
            if (!mem_en_q) begin
               if (bus.mem_done) begin
                  resp_ok = 1'b1;
                  state_d = StDone;
               end else if (wait_q == WaitLast) begin
                  resp_timeout = 1'b1;
                  state_d      = StDone;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         wait_q      <= '0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_data_q   <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         mem_en_q   <= grant_data | grant_fetch;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         if (grant_data) begin
            // Read+write together is served as a write and flagged.
            mem_wr_q    <= bus.mem_write;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            if (bus.mem_read && bus.mem_write) err_q <= 1'b1;
         end else if (grant_fetch) begin
            mem_wr_q   <= 1'b0;
            mem_addr_q <= bus.if_addr;
         end
         if (resp_ok || resp_timeout) begin
            if (state_q == StData) begin
               dm_rdata_q <= resp_ok ? bus.mem_rdata : '0;
               dm_valid_q <= 1'b1;
            end else begin
               if_data_q  <= resp_ok ? bus.mem_rdata : '0;
               if_valid_q <= 1'b1;
            end
            if (resp_timeout) err_q <= 1'b1;
         end
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_data   = if_data_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.dm_valid  = dm_valid_q;
   assign bus.err       = err_q;
   assign bus.if_stall  = bus.if_req & ~if_valid_q;
   assign bus.dm_stall  = data_req & ~dm_valid_q;
   assign bus.halted    = bus.halt & (state_q == StIdle) & ~data_req;

endmodule
